// File: rtl/bp_stall_profiler_ctrl_if.sv
// Host read port of the stall profiler. Signal suffixes name the direction as seen by the controller.
// Handshake: a read is accepted on a clock edge where rd_v_i & rd_ready_o; the host holds rd_v_i and rd_addr_i until then; rd_data_v_o/rd_data_o follow exactly one cycle after accept.
interface bp_stall_profiler_ctrl_if #(
    parameter int counter_width_p = 32
);
    logic                       rd_v_i;
    logic [4:0]                 rd_addr_i;
    logic                       rd_ready_o;
    logic                       rd_data_v_o;
    logic [counter_width_p-1:0] rd_data_o;

    modport master (
        output rd_v_i,
        output rd_addr_i,
        input  rd_ready_o,
        input  rd_data_v_o,
        input  rd_data_o
    );

    modport slave (
        input  rd_v_i,
        input  rd_addr_i,
        output rd_ready_o,
        output rd_data_v_o,
        output rd_data_o
    );
endinterface

// File: rtl/bp_stall_profiler_ctrl.sv
// Stall-reason counter bank controller: run coalescing, RMW flush into a 32-entry bank, shared read port, clear sweep.
// Optional BP_PROFILER_TOTAL_CYCLES_EN adds an enabled-RUN-cycle counter readable at index 31.
module bp_stall_profiler_ctrl #(
    parameter int counter_width_p = 32,
    parameter int acc_width_p     = 8,
    parameter int starve_limit_p  = 4,
    parameter int drop_width_p    = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       en_i,
    input  logic                       stall_v_i,
    input  logic [4:0]                 stall_reason_i,
    input  logic                       clear_i,
    output logic                       busy_o,
    bp_stall_profiler_ctrl_if.slave    rd_if,
    output logic [drop_width_p-1:0]    drop_count_o
);

    localparam int wait_w_lp = $clog2(starve_limit_p + 1);

    // CLEAR encodes as zero so the all-zero reset state starts the sweep; busy_o is the state decode.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [4:0]                 clr_idx_q, clr_idx_d;

    logic [counter_width_p-1:0] mem_q [32];

    logic [4:0]                 acc_reason_q, acc_reason_d;
    logic [acc_width_p-1:0]     acc_cnt_q, acc_cnt_d;

    logic                       fb_v_q, fb_v_d;
    logic [4:0]                 fb_reason_q, fb_reason_d;
    logic [acc_width_p-1:0]     fb_cnt_q, fb_cnt_d;

    logic                       f1_v_q;
    logic [4:0]                 f1_idx_q;
    logic [counter_width_p-1:0] f1_base_q;
    logic [acc_width_p-1:0]     f1_cnt_q;
    logic [counter_width_p-1:0] f1_wdata;

    logic [wait_w_lp-1:0]       wait_q, wait_d;
    logic [drop_width_p-1:0]    drop_q, drop_d;

    logic                       rd_data_v_q;
    logic [counter_width_p-1:0] rd_data_q;

    logic                       run;
    logic                       host_prio;
    logic                       flush_go;
    logic                       rd_ready;
    logic                       rd_accept;
    logic [4:0]                 port_addr;
    logic [counter_width_p-1:0] port_data;
    logic [counter_width_p-1:0] total_rd;
    logic [counter_width_p-1:0] host_data;
    logic                       stall_ev;
    logic                       fb_free;
    logic                       acc_full;

    // ------------------------------------------------------------------
    // Read-port arbitration and the shared read with write bypass
    // ------------------------------------------------------------------
    assign run       = (state_q == RUN);
    assign host_prio = (wait_q == wait_w_lp'(starve_limit_p));
    assign flush_go  = run & ~clear_i & fb_v_q & ~host_prio;
    assign rd_ready  = run & ~clear_i & ~flush_go;
    assign rd_accept = rd_if.rd_v_i & rd_ready;
    assign port_addr = flush_go ? fb_reason_q : rd_if.rd_addr_i;

    assign f1_wdata  = f1_base_q + counter_width_p'(f1_cnt_q);
    // A read of the index being written this cycle must see the new sum, not the stale entry.
    assign port_data = (f1_v_q && (f1_idx_q == port_addr)) ? f1_wdata : mem_q[port_addr];
    assign host_data = (rd_if.rd_addr_i == 5'd31) ? total_rd : port_data;

`ifdef BP_PROFILER_TOTAL_CYCLES_EN
    logic [counter_width_p-1:0] total_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            total_q <= '0;
        end else if (!run) begin
            total_q <= '0;
        end else if (en_i) begin
            total_q <= total_q + counter_width_p'(1);
        end
    end

    assign total_rd = total_q;
`else
    assign total_rd = '0;
`endif

    // ------------------------------------------------------------------
    // FSM, accumulator and flush buffer next state
    // ------------------------------------------------------------------
    assign stall_ev = en_i & stall_v_i & (stall_reason_i != 5'd31);
    assign fb_free  = ~fb_v_q | flush_go;
    assign acc_full = (acc_cnt_q == {acc_width_p{1'b1}});

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        acc_reason_d = acc_reason_q;
        acc_cnt_d    = acc_cnt_q;
        fb_v_d       = fb_v_q & ~flush_go;
        fb_reason_d  = fb_reason_q;
        fb_cnt_d     = fb_cnt_q;
        drop_d       = drop_q;

        case (state_q)
            CLEAR: begin
                acc_cnt_d = '0;
                fb_v_d    = 1'b0;
                if (clear_i) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == 5'd31) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 5'd1;
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                    acc_cnt_d = '0;
                    fb_v_d    = 1'b0;
                end else if (stall_ev) begin
                    if ((acc_cnt_q != '0) && (stall_reason_i == acc_reason_q) && !acc_full) begin
                        acc_cnt_d = acc_cnt_q + acc_width_p'(1);
                    end else if (acc_cnt_q == '0) begin
                        acc_reason_d = stall_reason_i;
                        acc_cnt_d    = acc_width_p'(1);
                    end else if (fb_free) begin
                        fb_v_d       = 1'b1;
                        fb_reason_d  = acc_reason_q;
                        fb_cnt_d     = acc_cnt_q;
                        acc_reason_d = stall_reason_i;
                        acc_cnt_d    = acc_width_p'(1);
                    end else if (drop_q != {drop_width_p{1'b1}}) begin
                        drop_d = drop_q + drop_width_p'(1);
                    end
                end else if (!en_i && (acc_cnt_q != '0) && fb_free) begin
                    // Frozen: push the partial run out so the bank becomes consistent.
                    fb_v_d      = 1'b1;
                    fb_reason_d = acc_reason_q;
                    fb_cnt_d    = acc_cnt_q;
                    acc_cnt_d   = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Starvation counter: only a request that keeps waiting accumulates credit.
    always_comb begin
        wait_d = wait_q;
        if (rd_accept || !rd_if.rd_v_i) begin
            wait_d = '0;
        end else if (!host_prio) begin
            wait_d = wait_q + wait_w_lp'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            acc_reason_q <= '0;
            acc_cnt_q    <= '0;
            fb_v_q       <= 1'b0;
            fb_reason_q  <= '0;
            fb_cnt_q     <= '0;
            wait_q       <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            acc_reason_q <= acc_reason_d;
            acc_cnt_q    <= acc_cnt_d;
            fb_v_q       <= fb_v_d;
            fb_reason_q  <= fb_reason_d;
            fb_cnt_q     <= fb_cnt_d;
            wait_q       <= wait_d;
            drop_q       <= drop_d;
        end
    end

    // F0 captures the current entry; F1 writes it back incremented on the next cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            f1_v_q    <= 1'b0;
            f1_idx_q  <= '0;
            f1_base_q <= '0;
            f1_cnt_q  <= '0;
        end else begin
            f1_v_q <= flush_go;
            if (flush_go) begin
                f1_idx_q  <= fb_reason_q;
                f1_base_q <= port_data;
                f1_cnt_q  <= fb_cnt_q;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!run) begin
            mem_q[clr_idx_q] <= '0;
        end else if (f1_v_q) begin
            mem_q[f1_idx_q] <= f1_wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data_v_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_data_v_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= host_data;
            end
        end
    end

    assign busy_o            = ~run;
    assign rd_if.rd_ready_o  = rd_ready;
    assign rd_if.rd_data_v_o = rd_data_v_q;
    assign rd_if.rd_data_o   = rd_data_q;
    assign drop_count_o      = drop_q;

endmodule

// File: tb/tb_bp_stall_profiler_ctrl.sv
// Bench for bp_stall_profiler_ctrl: directed table, hand sequences, randomized traffic against a rule-level model.
// A second instance with 8-bit counters exercises counter wrap.
module tb_bp_stall_profiler_ctrl;

  localparam int CW        = 32;
  localparam int AW        = 8;
  localparam int SL        = 4;
  localparam int DW        = 16;
  localparam int ACC_MAX   = (1 << AW) - 1;
  localparam int DROP_MAX  = (1 << DW) - 1;
`ifdef BP_PROFILER_TOTAL_CYCLES_EN
  localparam bit TOT_EN = 1'b1;
`else
  localparam bit TOT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          en, sv, clr;
  logic [4:0]    reason;
  logic          busy;
  logic [DW-1:0] drops;

  logic          w_en, w_sv, w_clr;
  logic [4:0]    w_reason;
  logic          w_busy;
  logic [DW-1:0] w_drops;

  bp_stall_profiler_ctrl_if #(.counter_width_p(CW)) rif ();
  bp_stall_profiler_ctrl_if #(.counter_width_p(8))  rif_w ();

  bp_stall_profiler_ctrl #(
    .counter_width_p(CW), .acc_width_p(AW), .starve_limit_p(SL), .drop_width_p(DW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .en_i(en), .stall_v_i(sv), .stall_reason_i(reason),
    .clear_i(clr), .busy_o(busy), .rd_if(rif), .drop_count_o(drops)
  );

  bp_stall_profiler_ctrl #(
    .counter_width_p(8), .acc_width_p(AW), .starve_limit_p(SL), .drop_width_p(DW)
  ) dut_w (
    .aclk(aclk), .aresetn(aresetn), .en_i(w_en), .stall_v_i(w_sv), .stall_reason_i(w_reason),
    .clear_i(w_clr), .busy_o(w_busy), .rd_if(rif_w), .drop_count_o(w_drops)
  );

  // ---------------- scoreboard / counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int r; int c; } ent_t;
  bit          m_run = 1'b0;
  int          m_cidx = 0;
  int unsigned bank[32];
  int          m_acc_r = 0, m_acc_c = 0;
  ent_t        fbq[$];
  int          m_wait = 0;
  int          m_drops = 0;
  int unsigned m_tot = 0;

  // observed samples for drivers
  bit          s_acc, s_rdv, s_busy;
  logic [31:0] s_rdata;
  bit          s_wacc, s_wrdv;
  logic [7:0]  s_wrdata;

  // One clock: check outputs at negedge against the model, advance the model, return after posedge.
  task automatic tick();
    bit   ovr, fgo, rdy, acc, ev, free;
    ent_t e;
    @(negedge aclk);
    ovr = (m_wait >= SL);
    fgo = m_run && !clr && (fbq.size() != 0) && !ovr;
    rdy = m_run && !clr && !fgo;
    check("busy", busy, !m_run);
    check("rd_ready", rif.rd_ready_o, rdy);
    check("drop_count", drops, m_drops);
    s_busy  = busy;
    s_rdv   = rif.rd_data_v_o;
    s_rdata = rif.rd_data_o;
    s_acc   = rif.rd_v_i && rif.rd_ready_o;
    s_wacc   = rif_w.rd_v_i && rif_w.rd_ready_o;
    s_wrdv   = rif_w.rd_data_v_o;
    s_wrdata = rif_w.rd_data_o;
    check("rd_data_v", s_rdv, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      logic [31:0] x;
      x = exp_q.pop_front();
      if (s_rdv) check("rd_data", s_rdata, x);
    end
    acc = rif.rd_v_i && rdy;
    if (acc) exp_q.push_back((rif.rd_addr_i == 5'd31) ? (TOT_EN ? m_tot : 32'd0) : bank[rif.rd_addr_i]);
    if (fgo) begin
      e = fbq.pop_front();
      bank[e.r] += e.c;
    end
    if (acc || !rif.rd_v_i) m_wait = 0;
    else if (m_wait < SL) m_wait++;
    if (!m_run) m_tot = 0;
    else if (en) m_tot++;
    if (!m_run || clr) begin
      m_acc_c = 0;
      fbq.delete();
    end else begin
      ev   = en && sv && (reason != 5'd31);
      free = (fbq.size() == 0);
      if (ev) begin
        if (m_acc_c != 0 && int'(reason) == m_acc_r && m_acc_c < ACC_MAX) m_acc_c++;
        else if (m_acc_c == 0) begin m_acc_r = reason; m_acc_c = 1; end
        else if (free) begin
          fbq.push_back('{m_acc_r, m_acc_c});
          m_acc_r = reason; m_acc_c = 1;
        end else if (m_drops < DROP_MAX) m_drops++;
      end else if (!en && m_acc_c != 0 && free) begin
        fbq.push_back('{m_acc_r, m_acc_c});
        m_acc_c = 0;
      end
    end
    if (!m_run) for (int i = 0; i < 32; i++) bank[i] = 0;
    if (m_run) begin
      if (clr) begin m_run = 1'b0; m_cidx = 0; end
    end else if (clr) m_cidx = 0;
    else if (m_cidx == 31) begin m_run = 1'b1; m_cidx = 0; end
    else m_cidx++;
    @(posedge aclk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_read(input logic [4:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    rif.rd_v_i = 1'b1;
    rif.rd_addr_i = a;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      got = s_acc;
    end
    rif.rd_v_i = 1'b0;
    check("rd_accept", got, 1);
    tick();
    d = s_rdata;
  endtask

  task automatic stalls(input logic [4:0] r, input int n);
    en = 1'b1; sv = 1'b1; reason = r;
    repeat (n) tick();
    en = 1'b0; sv = 1'b0;
    repeat (6) tick();
  endtask

  typedef struct {
    logic [4:0]  reason;
    int          n;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[5];

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, d29, d30;
    int cnt, lat, maxlat, d0;
    bit got;
    tbl[0] = '{5'd3,  10,  32'd10};
    tbl[1] = '{5'd5,  300, 32'd300};
    tbl[2] = '{5'd0,  1,   32'd1};
    tbl[3] = '{5'd30, 256, 32'd256};
    tbl[4] = '{5'd12, 510, 32'd510};
    for (int i = 0; i < 32; i++) bank[i] = 0;

    en = 0; sv = 0; clr = 0; reason = 0; rif.rd_v_i = 0; rif.rd_addr_i = 0;
    w_en = 0; w_sv = 0; w_clr = 0; w_reason = 0; rif_w.rd_v_i = 0; rif_w.rd_addr_i = 0;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("reset_busy", busy, 1);
    check("reset_ready", rif.rd_ready_o, 0);
    check("reset_rdv", rif.rd_data_v_o, 0);
    check("reset_drops", drops, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // initial sweep: busy for 32 cycles, then all entries read back 0
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!s_busy) break;
      cnt++;
    end
    check("sweep_len", cnt, 32);
    for (int a = 0; a < 32; a++) begin
      host_read(5'(a), d);
      check("post_reset_rd", d, 0);
    end

    // directed run-length table
    for (int i = 0; i < 5; i++) begin
      stalls(tbl[i].reason, tbl[i].n);
      host_read(tbl[i].reason, d);
      check("table_count", d, tbl[i].exp);
    end

    // clear, then re-clear mid-sweep at index 20
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (20) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!s_busy) break;
      cnt++;
    end
    check("reclear_len", cnt, 32);
    host_read(5'd3, d);
    check("cleared_idx3", d, 0);
    en = 1'b1; repeat (17) tick(); en = 1'b0;
    host_read(5'd31, d);
    check("total_cycles", d, TOT_EN ? 32'd17 : 32'd0);

    // alternating reasons with a host polling idx 0
    d0 = drops; maxlat = 0; lat = 0;
    rif.rd_v_i = 1'b1; rif.rd_addr_i = 5'd0; en = 1'b1; sv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      reason = (i % 2 == 0) ? 5'd30 : 5'd29;
      tick();
      lat++;
      if (s_acc) begin
        if (lat > maxlat) maxlat = lat;
        lat = 0;
      end
    end
    rif.rd_v_i = 1'b0; en = 1'b0; sv = 1'b0;
    repeat (6) tick();
    check("host_latency_ok", (maxlat >= 1 && maxlat <= SL + 1), 1);
    host_read(5'd30, d30);
    host_read(5'd29, d29);
    check("alt_conservation", d30 + d29 + (drops - d0), 20);

    // wrap on the 8-bit instance: 254 then +3 -> 1
    w_en = 1'b1; w_sv = 1'b1; w_reason = 5'd7;
    repeat (254) tick();
    w_en = 1'b0; w_sv = 1'b0; repeat (6) tick();
    w_en = 1'b1; w_sv = 1'b1;
    repeat (3) tick();
    w_en = 1'b0; w_sv = 1'b0; repeat (6) tick();
    rif_w.rd_v_i = 1'b1; rif_w.rd_addr_i = 5'd7; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); got = s_wacc; end
    rif_w.rd_v_i = 1'b0;
    check("wrap_accept", got, 1);
    tick();
    check("wrap_rdv", s_wrdv, 1);
    check("wrap_value", s_wrdata, 8'd1);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      sv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) reason = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4) * 7);
      clr = ($urandom_range(0, 399) == 0);
      if (!rif.rd_v_i || s_acc) begin
        rif.rd_v_i = ($urandom_range(0, 3) == 0);
        rif.rd_addr_i = 5'($urandom_range(0, 31));
      end
      tick();
    end
    en = 1'b0; sv = 1'b0; clr = 1'b0; rif.rd_v_i = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    for (int a = 0; a < 32; a++) host_read(5'(a), d);
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
